// File: rtl/huffman_merge_sched_if.sv
// Scheduler-side bus: symbol counts in, shared node-sorter port pair, and the code outputs.
interface huffman_merge_sched_if;
  logic        CNT_valid;
  logic [47:0] CNT;
  logic [47:0] in_Aid_all;
  logic [47:0] in_CNT_all;
  logic [47:0] out_Aid_all;
  logic [47:0] out_CNT_all;
  logic        code_valid;
  logic        busy;
  logic [47:0] HC;
  logic [47:0] M;

  modport slave (
    input  CNT_valid, CNT, out_Aid_all, out_CNT_all,
    output in_Aid_all, in_CNT_all, code_valid, busy, HC, M
  );

  modport master (
    output CNT_valid, CNT, out_Aid_all, out_CNT_all,
    input  in_Aid_all, in_CNT_all, code_valid, busy, HC, M
  );
endinterface

// File: rtl/huffman_merge_sched.sv
// Huffman merge scheduler: five merge rounds over an external sorter, per-symbol
// code/mask accumulation in one lane instance per symbol.
module huffman_merge_lane #(
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             merge,
  input  logic             in_l,
  input  logic             in_s,
  output logic [VEC_W-1:0] hc,
  output logic [VEC_W-1:0] m
);
  logic [$clog2(VEC_W)-1:0] len;

  // A symbol in L gets a 1 at its current depth, a symbol in S gets a 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hc  <= '0;
      m   <= '0;
      len <= '0;
    end else if (clear) begin
      hc  <= '0;
      m   <= '0;
      len <= '0;
    end else if (merge && (in_l || in_s)) begin
      hc[len] <= in_l;
      m       <= {m[VEC_W-2:0], 1'b1};
      len     <= len + 1'b1;
    end
  end
endmodule

module huffman_merge_sched #(
  parameter int SORT_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  huffman_merge_sched_if.slave  bus
);
  localparam int NUM_LANES = 6;
  localparam int VEC_W     = 8;
  localparam int ROUNDS    = NUM_LANES - 1;
  localparam int IW        = $clog2(NUM_LANES);
  localparam int WT_W      = (SORT_LAT > 1) ? $clog2(SORT_LAT) : 1;

  // Element e holds field [8e+7:8e], i.e. slot 5-e / symbol 6-e.
  typedef logic [NUM_LANES-1:0][VEC_W-1:0] vec_t;
  typedef enum logic [2:0] {IDLE, LOAD, SORT, MERGE, DONE} state_t;

  state_t          state;
  logic [WT_W-1:0] wt;
  logic [2:0]      rnd;
  vec_t            node_aid, node_cnt;
  vec_t            in_aid, in_cnt;
  vec_t            out_aid, out_cnt;
  vec_t            init_aid;
  vec_t            hc_v, m_v;
  logic            code_valid, busy;

  logic            l_ok, s_ok;
  logic [IW-1:0]   l_idx, s_idx, pos;
  logic [VEC_W-1:0] l_aid, s_aid, l_cnt, s_cnt, m_cnt;
  logic [VEC_W:0]  sum;
  vec_t            nxt_aid, nxt_cnt;

  assign out_aid        = bus.out_Aid_all;
  assign out_cnt        = bus.out_CNT_all;
  assign bus.in_Aid_all = in_aid;
  assign bus.in_CNT_all = in_cnt;
  assign bus.HC         = hc_v;
  assign bus.M          = m_v;
  assign bus.code_valid = code_valid;
  assign bus.busy       = busy;

  // Merge step: L/S are the first two live slots scanning from the smallest end.
  always_comb begin
    l_ok  = 1'b0;
    s_ok  = 1'b0;
    l_idx = '0;
    s_idx = '0;
    for (int e = 0; e < NUM_LANES; e++) begin
      if (out_aid[e] != '0) begin
        if (!l_ok) begin
          l_ok  = 1'b1;
          l_idx = IW'(e);
        end else if (!s_ok) begin
          s_ok  = 1'b1;
          s_idx = IW'(e);
        end
      end
    end
    l_aid = l_ok ? out_aid[l_idx] : '0;
    l_cnt = l_ok ? out_cnt[l_idx] : '0;
    s_aid = s_ok ? out_aid[s_idx] : '0;
    s_cnt = s_ok ? out_cnt[s_idx] : '0;
    sum   = {1'b0, l_cnt} + {1'b0, s_cnt};
    m_cnt = sum[VEC_W] ? '1 : sum[VEC_W-1:0];

    // Survivors keep sorter order from slot 0, then the merged node, then empties.
    nxt_aid = '0;
    nxt_cnt = '0;
    pos     = IW'(NUM_LANES - 1);
    for (int e = NUM_LANES - 1; e >= 0; e--) begin
      if (out_aid[e] != '0 && !(l_ok && IW'(e) == l_idx) && !(s_ok && IW'(e) == s_idx)) begin
        nxt_aid[pos] = out_aid[e];
        nxt_cnt[pos] = out_cnt[e];
        pos          = pos - 1'b1;
      end
    end
    nxt_aid[pos] = l_aid | s_aid;
    nxt_cnt[pos] = m_cnt;
  end

  for (genvar e = 0; e < NUM_LANES; e++) begin : g_lane
    assign init_aid[e] = VEC_W'(1) << (NUM_LANES - 1 - e);

    huffman_merge_lane #(.VEC_W(VEC_W)) u_lane (
      .clk   (clk),
      .reset (reset),
      .clear (state == IDLE && bus.CNT_valid),
      .merge (state == MERGE),
      .in_l  (l_aid[NUM_LANES-1-e]),
      .in_s  (s_aid[NUM_LANES-1-e]),
      .hc    (hc_v[e]),
      .m     (m_v[e])
    );
  end

  // Node registers take the counts on acceptance; in_* only move on edges into SORT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wt         <= '0;
      rnd        <= '0;
      node_aid   <= '0;
      node_cnt   <= '0;
      in_aid     <= '0;
      in_cnt     <= '0;
      code_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.CNT_valid) begin
          node_aid <= init_aid;
          node_cnt <= bus.CNT;
          busy     <= 1'b1;
          state    <= LOAD;
        end
        LOAD: begin
          in_aid <= node_aid;
          in_cnt <= node_cnt;
          rnd    <= '0;
          wt     <= '0;
          state  <= SORT;
        end
        SORT: begin
          if (wt == WT_W'(SORT_LAT - 1)) state <= MERGE;
          else                           wt    <= wt + 1'b1;
        end
        MERGE: begin
          node_aid <= nxt_aid;
          node_cnt <= nxt_cnt;
          rnd      <= rnd + 1'b1;
          wt       <= '0;
          if (rnd == 3'(ROUNDS - 1)) begin
            code_valid <= 1'b1;
            state      <= DONE;
          end else begin
            in_aid <= nxt_aid;
            in_cnt <= nxt_cnt;
            state  <= SORT;
          end
        end
        DONE: begin
          code_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_huffman_merge_sched.sv
// Two schedulers (sorter latency 1 and 3) share stimulus; each has a descending-sort
// sorter model and a queue-based Huffman reference checked cycle by cycle.
module tb_huffman_merge_sched;
  typedef struct packed {
    logic [47:0] hc;
    logic [47:0] m;
    logic [7:0]  fcnt;
  } res_t;

  localparam logic [47:0] CLASSIC    = 48'h05090C0D102D;
  localparam logic [47:0] CLASSIC_HC = 48'h030203020001;
  localparam logic [47:0] CLASSIC_M  = 48'h0F0F07070701;
  localparam logic [47:0] SAT        = 48'h646E78828C96;
  localparam logic [47:0] OTHER      = 48'h010203040506;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnt_valid = 1'b0;
  logic [47:0] cnt = '0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [199:0] act, input logic [199:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Stable descending sort of six (id, count) slots; returns {ids, counts}.
  function automatic logic [95:0] sort_nodes(input logic [47:0] aid, input logic [47:0] c);
    logic [7:0]  a [6];
    logic [7:0]  v [6];
    logic [7:0]  t;
    logic [95:0] r;
    for (int i = 0; i < 6; i++) begin
      a[i] = aid[47-8*i -: 8];
      v[i] = c[47-8*i -: 8];
    end
    for (int i = 1; i < 6; i++)
      for (int j = i; j > 0; j--)
        if (v[j-1] < v[j]) begin
          t = v[j]; v[j] = v[j-1]; v[j-1] = t;
          t = a[j]; a[j] = a[j-1]; a[j-1] = t;
        end
    for (int i = 0; i < 6; i++) begin
      r[95-8*i -: 8] = a[i];
      r[47-8*i -: 8] = v[i];
    end
    return r;
  endfunction

  // Textbook Huffman on a node list: repeatedly sort, merge the two smallest.
  function automatic res_t ref_huff(input logic [47:0] c);
    int   cn[$];
    int   ms[$];
    int   hc [6];
    int   m [6];
    int   ln [6];
    int   lc, lm, sc, sm, t;
    res_t r;
    for (int k = 0; k < 6; k++) begin
      ms.push_back(1 << k);
      cn.push_back(int'(c[47-8*k -: 8]));
      hc[k] = 0; m[k] = 0; ln[k] = 0;
    end
    repeat (5) begin
      for (int i = 1; i < cn.size(); i++)
        for (int j = i; j > 0; j--)
          if (cn[j-1] < cn[j]) begin
            t = cn[j]; cn[j] = cn[j-1]; cn[j-1] = t;
            t = ms[j]; ms[j] = ms[j-1]; ms[j-1] = t;
          end
      lc = cn.pop_back(); lm = ms.pop_back();
      sc = cn.pop_back(); sm = ms.pop_back();
      for (int k = 0; k < 6; k++) begin
        if (((lm >> k) & 1) != 0) hc[k] += (1 << ln[k]);
        if ((((lm | sm) >> k) & 1) != 0) begin
          ln[k]++;
          m[k] = 2 * m[k] + 1;
        end
      end
      cn.push_back((lc + sc > 255) ? 255 : lc + sc);
      ms.push_back(lm | sm);
    end
    for (int k = 0; k < 6; k++) begin
      r.hc[47-8*k -: 8] = 8'(hc[k]);
      r.m[47-8*k -: 8]  = 8'(m[k]);
    end
    r.fcnt = 8'(cn[0]);
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam int N   = 1 + 5 * (LAT + 1);

    huffman_merge_sched_if bus ();
    huffman_merge_sched #(.SORT_LAT(LAT)) dut (.clk(clk), .reset(rst_n), .bus(bus));

    logic [95:0]  pipe [LAT];
    logic [193:0] outs;
    logic [7:0]   fin_cnt, fin_aid;
    logic         pend = 1'b0;
    int           age = 0;
    res_t         want;
    logic [95:0]  prev_in = '0;

    assign bus.CNT_valid   = cnt_valid;
    assign bus.CNT         = cnt;
    assign bus.out_Aid_all = pipe[LAT-1][95:48];
    assign bus.out_CNT_all = pipe[LAT-1][47:0];
    assign outs    = {bus.HC, bus.M, bus.in_Aid_all, bus.in_CNT_all, bus.code_valid, bus.busy};
    assign fin_cnt = dut.node_cnt[5];
    assign fin_aid = dut.node_aid[5];

    always @(posedge clk) begin
      pipe[0] <= sort_nodes(bus.in_Aid_all, bus.in_CNT_all);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    // age = edges since the accepting edge; the run ends on the edge after code_valid.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pend <= 1'b0;
        age  <= 0;
      end else if (!pend) begin
        if (cnt_valid) begin
          pend <= 1'b1;
          age  <= 0;
          want <= ref_huff(cnt);
        end
      end else begin
        age <= age + 1;
        if (age == N) pend <= 1'b0;
      end
    end

    always @(negedge clk) begin
      check($sformatf("busy_lat%0d", LAT), 200'(bus.busy), 200'(pend));
      check($sformatf("code_valid_lat%0d", LAT), 200'(bus.code_valid), 200'(pend && age == N));
      if (pend && age == N) begin
        check($sformatf("hc_lat%0d", LAT), 200'(bus.HC), 200'(want.hc));
        check($sformatf("m_lat%0d", LAT), 200'(bus.M), 200'(want.m));
        check($sformatf("final_cnt_lat%0d", LAT), 200'(fin_cnt), 200'(want.fcnt));
        check($sformatf("final_aid_lat%0d", LAT), 200'(fin_aid), 200'(8'h3F));
      end
      if (rst_n && {bus.in_Aid_all, bus.in_CNT_all} != prev_in)
        check($sformatf("in_stable_lat%0d", LAT),
              200'(pend && age >= 1 && (age - 1) % (LAT + 1) == 0 && age <= 1 + 4 * (LAT + 1)),
              200'(1));
      prev_in <= {bus.in_Aid_all, bus.in_CNT_all};
    end
  end

  function automatic logic [47:0] rand_cnt();
    logic [47:0] r;
    for (int i = 0; i < 6; i++)
      r[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(1, 255));
    return r;
  endfunction

  task automatic strobe(input logic [47:0] v);
    @(negedge clk);
    cnt       = v;
    cnt_valid = 1'b1;
    @(negedge clk);
    cnt_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!g_dut[0].pend && !g_dut[1].pend && !g_dut[0].bus.busy && !g_dut[1].bus.busy) break;
      @(negedge clk);
    end
    check("idle", 200'({g_dut[0].bus.busy, g_dut[1].bus.busy}), 200'(0));
  endtask

  task automatic check_classic(input string tag);
    check({tag, "_hc_lat1"}, 200'(g_dut[0].bus.HC), 200'(CLASSIC_HC));
    check({tag, "_m_lat1"},  200'(g_dut[0].bus.M),  200'(CLASSIC_M));
    check({tag, "_hc_lat3"}, 200'(g_dut[1].bus.HC), 200'(CLASSIC_HC));
    check({tag, "_m_lat3"},  200'(g_dut[1].bus.M),  200'(CLASSIC_M));
    check({tag, "_fin_lat1"}, 200'({g_dut[0].fin_aid, g_dut[0].fin_cnt}), 200'(16'h3F64));
    check({tag, "_fin_lat3"}, 200'({g_dut[1].fin_aid, g_dut[1].fin_cnt}), 200'(16'h3F64));
  endtask

  initial begin
    logic ok;
    repeat (2) @(negedge clk);
    check("reset_lat1", 200'(g_dut[0].outs), 200'(0));
    check("reset_lat3", 200'(g_dut[1].outs), 200'(0));
    #1 rst_n = 1'b1;

    strobe(CLASSIC);
    wait_idle();
    check_classic("classic");

    // Second strobe lands in round 3 of the latency-1 unit and must be ignored.
    strobe(CLASSIC);
    repeat (5) @(negedge clk);
    cnt       = OTHER;
    cnt_valid = 1'b1;
    @(negedge clk);
    cnt_valid = 1'b0;
    wait_idle();
    check_classic("busy_reject");

    // Abort during the round-2 merge of the latency-1 unit.
    strobe(CLASSIC);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_lat1", 200'(g_dut[0].outs), 200'(0));
    check("abort_lat3", 200'(g_dut[1].outs), 200'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    strobe(CLASSIC);
    wait_idle();
    check_classic("after_abort");

    strobe(SAT);
    wait_idle();
    for (int g = 0; g < 2; g++) begin
      ok = 1'b1;
      for (int i = 0; i < 6; i++)
        if (((g == 0) ? g_dut[0].bus.M[8*i +: 8] : g_dut[1].bus.M[8*i +: 8]) == 8'h00) ok = 1'b0;
      check($sformatf("sat_m_nonzero_%0d", g), 200'(ok), 200'(1));
    end
    check("sat_fin_lat1", 200'(g_dut[0].fin_cnt), 200'(8'hFF));
    check("sat_fin_lat3", 200'(g_dut[1].fin_cnt), 200'(8'hFF));

    // Strobe held high: the code_valid-cycle strobe is dropped, the next IDLE one is taken.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cnt       = rand_cnt();
      cnt_valid = 1'b1;
    end
    @(negedge clk);
    cnt_valid = 1'b0;
    wait_idle();

    for (int r = 0; r < 40; r++) begin
      strobe(rand_cnt());
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/huffman_merge_sched.md
# huffman_merge_sched

Merge scheduler for the Huffman encoder. It takes the six symbol counts (`CNT`, valid on `CNT_valid`) and runs the five tree-combination rounds. Each round shares the external node sorter through the `in_Aid_all`/`in_CNT_all` → `out_Aid_all`/`out_CNT_all` port pair. It accumulates per-symbol code bits and emits `HC`/`M` with a one-cycle `code_valid`.

## Interface
- `SORT_LAT`, default 1: sorter latency in cycles (≥1) from stable inputs to valid outputs.
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `CNT_valid` input 1: one-cycle strobe; `CNT` is valid when high.
- `CNT` input 48: six 8-bit counts; symbol k (1..6) occupies [55-8k:48-8k].
- `out_Aid_all` input 48: sorter output, six 8-bit node ids, descending by count.
- `out_CNT_all` input 48: sorter output counts, same slot order.
- `in_Aid_all` output 48: node ids to the sorter; registered.
- `in_CNT_all` output 48: node counts to the sorter; registered.
- `code_valid` output 1: one-cycle pulse; `HC` and `M` are final.
- `HC` output 48: code per symbol, same packing as `CNT`, LSB-aligned.
- `M` output 48: mask per symbol; low len_k bits set.
- `busy` output 1: high from LOAD through DONE inclusive.

## Operation
- **Node id encoding.** Aid = {2'b00, 6-bit symbol-membership mask}; bit k-1 represents symbol k. Aid = 0 marks an empty slot, which always carries CNT = 0.
- **FSM states:** IDLE → LOAD → SORT → MERGE → (SORT | DONE) → IDLE.
- **IDLE.** On `CNT_valid`=1, capture `CNT` and go to LOAD.
  - Clear `HC`, `M` and the per-symbol lengths at the same time.
  - `CNT_valid` in any other state is ignored.
- **LOAD.**
  - Node slot k gets Aid = 1<<(k-1) and CNT = symbol k's count.
  - Round counter = 0. Go to SORT.
- **SORT.**
  - Node registers drive `in_*`.
  - Wait counter runs SORT_LAT cycles, then go to MERGE.
- **MERGE.** Sample `out_*` on the exiting edge.
  - Scan slots 5 → 0 (slot 5 = least significant field, [7:0]) and take the first two slots with Aid ≠ 0.
  - First found = L (smallest); second = S.
  - For each symbol k in L, set HC_k bit[len_k] = 1. For each symbol k in S, set that bit to 0.
  - For each symbol in L|S: len_k += 1 and M_k = (M_k<<1)|1.
  - Next node list, in order: the sorted active nodes other than L and S, then {Aid = L|S, CNT = min(CNT_L + CNT_S, 255)}, then empty slots.
  - The sum uses 9-bit width and saturates at 8'hFF; it never wraps.
  - Round counter += 1. At 5, go to DONE; otherwise go to SORT.
- **DONE.**
  - Assert `code_valid` for this cycle only, then go to IDLE.
  - `HC` and `M` hold until the next accepted `CNT_valid`.
- **Zero counts.** A symbol with count 0 is still an active node; only Aid = 0 marks a slot empty.
- **Ties.** Tie order between equal counts is whatever the sorter outputs; the scheduler adds no tie-break.

## Timing
- **Reset.** Asynchronous, active-low. Forces:
  - state = IDLE;
  - `code_valid` = 0, `busy` = 0;
  - `HC`, `M`, `in_Aid_all`, `in_CNT_all` = 0;
  - all node, length and counter registers = 0.
- **Reset mid-operation.** Aborts immediately. No `code_valid` is produced for the aborted run.
- **Latency.** Let E0 be the edge that samples `CNT_valid`.
  - LOAD occupies the cycle after E0.
  - Each round is SORT_LAT + 1 cycles.
  - `code_valid` is high in the cycle after edge E0 + 1 + 5·(SORT_LAT+1). That is 11 edges for SORT_LAT = 1 and 21 for SORT_LAT = 3.
- **Sorter inputs.** `in_*` change only on the edge entering SORT; they are stable for the full SORT window.
- **Back-to-back runs.** A `CNT_valid` in the `code_valid` cycle is ignored. The earliest accepted strobe is in the following IDLE cycle.

## Test plan
- **Classic vector.** The bench sorter model is descending. Apply `CNT` = 48'h05090C0D102D with SORT_LAT = 1.
  - Required: `code_valid` 11 edges after the sampling edge.
  - Required: `HC` = 48'h030203020001 and `M` = 48'h0F0F07070701.
  - Required: final merged CNT = 8'h64 with Aid = 8'h3F.
- **Latency parameter.** Same vector with SORT_LAT = 3.
  - Required: identical `HC`/`M`; `code_valid` 21 edges after sampling.
  - Required: `in_*` stable through every SORT window.
- **Busy rejection.** Pulse `CNT_valid` with a different `CNT` during round 3.
  - Required: outputs equal the first run's results.
  - Required: exactly one `code_valid` pulse.
- **Reset mid-operation.** Drop `reset` low in MERGE of round 2.
  - Required: all outputs 0 asynchronously and no `code_valid`.
  - Then re-run the classic vector: correct result.
- **Saturation.** Apply `CNT` = 48'h646E78828C96.
  - Required: no merged count exceeds 8'hFF and none wraps.
  - Required: every `M` field is nonzero and `code_valid` fires on schedule.
